// File: rtl/acc_ctrl_pkg.sv
// Shared constants for the accumulator sequencer: opcodes, states, field widths.
// Opcode values match the ones the alu decodes.
package acc_ctrl_pkg;

    localparam int OPC_W    = 4;
    localparam int ADDR_LSB = 0;

    localparam logic [OPC_W-1:0] OP_CLA = 4'h0;
    localparam logic [OPC_W-1:0] OP_COM = 4'h1;
    localparam logic [OPC_W-1:0] OP_SHR = 4'h2;
    localparam logic [OPC_W-1:0] OP_CSL = 4'h3;
    localparam logic [OPC_W-1:0] OP_ADD = 4'h4;
    localparam logic [OPC_W-1:0] OP_STA = 4'h5;
    localparam logic [OPC_W-1:0] OP_LDA = 4'h6;
    localparam logic [OPC_W-1:0] OP_JMP = 4'h7;
    localparam logic [OPC_W-1:0] OP_HLT = 4'h9;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_FETCH  = 3'd1;
    localparam state_t ST_DECODE = 3'd2;
    localparam state_t ST_OPRD   = 3'd3;
    localparam state_t ST_EXEC   = 3'd4;
    localparam state_t ST_HALT   = 3'd5;

endpackage

// File: rtl/acc_ctrl_dec.sv
// Opcode classifier for the accumulator sequencer.
// Purely combinational; unknown opcodes report legal_o = 0.
module acc_ctrl_dec
    import acc_ctrl_pkg::*;
(
    input  logic [OPC_W-1:0] opcode_i,
    output logic             needs_operand_o,
    output logic             writes_acc_o,
    output logic             is_store_o,
    output logic             is_jump_o,
    output logic             is_halt_o,
    output logic             legal_o
);

    always_comb begin
        needs_operand_o = 1'b0;
        writes_acc_o    = 1'b0;
        is_store_o      = 1'b0;
        is_jump_o       = 1'b0;
        is_halt_o       = 1'b0;
        legal_o         = 1'b1;
        case (opcode_i)
            OP_CLA, OP_COM, OP_SHR, OP_CSL: writes_acc_o = 1'b1;
            OP_ADD, OP_LDA: begin
                needs_operand_o = 1'b1;
                writes_acc_o    = 1'b1;
            end
            OP_STA:  is_store_o = 1'b1;
            OP_JMP:  is_jump_o  = 1'b1;
            OP_HLT:  is_halt_o  = 1'b1;
            default: legal_o    = 1'b0;
        endcase
    end

endmodule

// File: rtl/acc_ctrl.sv
// Fetch/decode/execute sequencer for the 8-bit accumulator machine.
// Define ACC_CTRL_TRAP_EN to halt on illegal opcodes instead of skipping them.
module acc_ctrl
    import acc_ctrl_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic [DATA_W-1:0] alu_result,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] acc,
    output logic              busy,
    output logic              halted,
    output logic              illegal
);

    localparam int OPC_LSB = DATA_W - OPC_W;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] ir_q, ir_d;
`ifdef ACC_CTRL_TRAP_EN
    logic              ill_q, ill_d;
`endif

    logic [OPC_W-1:0]  ir_opc, rd_opc, dec_opc;
    logic [ADDR_W-1:0] ir_addr, rd_addr;
    logic              needs_operand, writes_acc, is_store;
    logic              is_jump, is_halt, legal;

    assign ir_opc  = ir_q[OPC_LSB +: OPC_W];
    assign ir_addr = ir_q[ADDR_LSB +: ADDR_W];
    assign rd_opc  = mem_rdata[OPC_LSB +: OPC_W];
    assign rd_addr = mem_rdata[ADDR_LSB +: ADDR_W];

    // IR is only loaded at the end of DECODE, so decode the fetched word directly.
    assign dec_opc = (state_q == ST_DECODE) ? rd_opc : ir_opc;

    acc_ctrl_dec u_dec (
        .opcode_i        (dec_opc),
        .needs_operand_o (needs_operand),
        .writes_acc_o    (writes_acc),
        .is_store_o      (is_store),
        .is_jump_o       (is_jump),
        .is_halt_o       (is_halt),
        .legal_o         (legal)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        acc_d   = acc_q;
        ir_d    = ir_q;
`ifdef ACC_CTRL_TRAP_EN
        ill_d   = ill_q;
`endif
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_FETCH;
            ST_FETCH: state_d = ST_DECODE;
            ST_DECODE: begin
                ir_d = mem_rdata;
                pc_d = pc_q + ADDR_W'(1);
                if (!legal) begin
`ifdef ACC_CTRL_TRAP_EN
                    state_d = ST_HALT;
                    ill_d   = 1'b1;
`else
                    state_d = ST_FETCH;
`endif
                end else if (is_jump) begin
                    pc_d    = rd_addr;
                    state_d = ST_FETCH;
                end else if (is_halt) begin
                    state_d = ST_HALT;
                end else if (needs_operand) begin
                    state_d = ST_OPRD;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_OPRD: state_d = ST_EXEC;
            ST_EXEC: begin
                if (writes_acc) acc_d = alu_result;
                state_d = ST_FETCH;
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            acc_q   <= '0;
            ir_q    <= '0;
`ifdef ACC_CTRL_TRAP_EN
            ill_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            acc_q   <= acc_d;
            ir_q    <= ir_d;
`ifdef ACC_CTRL_TRAP_EN
            ill_q   <= ill_d;
`endif
        end
    end

    // Gating with rst keeps a store in EXEC from landing on the reset edge.
    assign mem_we    = (state_q == ST_EXEC) && is_store && !rst;
    assign mem_re    = (state_q == ST_FETCH) || (state_q == ST_OPRD);
    assign mem_addr  = ((state_q == ST_OPRD) || (state_q == ST_EXEC))
                       ? ir_addr : pc_q;
    assign mem_wdata = alu_result;

    assign alu_op = (state_q == ST_EXEC) ? ir_opc : OP_CLA;
    assign alu_a  = acc_q;
    assign alu_b  = mem_rdata;

    assign pc     = pc_q;
    assign acc    = acc_q;
    assign busy   = (state_q != ST_IDLE) && (state_q != ST_HALT);
    assign halted = (state_q == ST_HALT);
`ifdef ACC_CTRL_TRAP_EN
    assign illegal = ill_q;
`else
    assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_acc_ctrl.sv
// Bench for acc_ctrl: models the alu and a registered-read memory,
// scoreboards memory writes and checks per-scenario results.
module tb_acc_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] mem_rdata = 8'h00;
    logic [7:0] alu_result;
    logic [3:0] mem_addr;
    logic       mem_re, mem_we;
    logic [7:0] mem_wdata;
    logic [3:0] alu_op;
    logic [7:0] alu_a, alu_b;
    logic [3:0] pc;
    logic [7:0] acc;
    logic       busy, halted, illegal;

    int errors = 0;
    int checks = 0;

    logic [7:0] mem [16];

    typedef struct {
        logic [3:0] a;
        logic [7:0] d;
    } wr_t;
    wr_t wq[$];

    acc_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .mem_rdata  (mem_rdata),
        .alu_result (alu_result),
        .mem_addr   (mem_addr),
        .mem_re     (mem_re),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .pc         (pc),
        .acc        (acc),
        .busy       (busy),
        .halted     (halted),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    always_comb begin
        alu_result = 8'h00;
        case (alu_op)
            4'h1: alu_result = ~alu_a;
            4'h2: alu_result = alu_a >> 1;
            4'h3: alu_result = {alu_a[6:0], alu_a[7]};
            4'h4: alu_result = alu_a + alu_b;
            4'h5: alu_result = alu_a;
            4'h6: alu_result = alu_b;
            default: alu_result = 8'h00;
        endcase
    end

    always @(posedge clk) begin
        if (mem_re) mem_rdata <= mem[mem_addr];
        if (mem_we) mem[mem_addr] = mem_wdata;
    end

    always @(negedge clk) begin
        wr_t e;
        if (mem_we) begin
            checks++;
            if (wq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write addr=%0d data=%0d", mem_addr, mem_wdata);
            end else begin
                e = wq.pop_front();
                if (mem_addr !== e.a || mem_wdata !== e.d) begin
                    errors++;
                    $display("FAIL write got addr=%0d data=%0d want addr=%0d data=%0d",
                             mem_addr, mem_wdata, e.a, e.d);
                end
            end
        end
        if (mem_re && mem_we) begin
            checks++;
            errors++;
            $display("FAIL re_we_exclusive got re=1 we=1 want not both");
        end
    end

    task automatic do_reset;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        wq.delete();
    endtask

    task automatic pulse_start;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic run_to_halt(output int n);
        n = 0;
        repeat (60) begin
            if (!halted) begin
                @(posedge clk);
                #1;
                n++;
            end
        end
        checks++;
        if (!halted) begin
            errors++;
            $display("FAIL halt_timeout got halted=0 want 1");
        end
    endtask

    task automatic load_arith;
        mem[0]  = 8'h6E;
        mem[1]  = 8'h4F;
        mem[2]  = 8'h5D;
        mem[3]  = 8'h90;
        mem[14] = 8'd51;
        mem[15] = 8'd59;
    endtask

    task automatic test_reset;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (pc !== 4'd0 || acc !== 8'd0) begin
            errors++;
            $display("FAIL reset_regs got pc=%0d acc=%0d want 0 0", pc, acc);
        end
        checks++;
        if ({busy, halted, illegal, mem_re, mem_we} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags got %b want 00000",
                     {busy, halted, illegal, mem_re, mem_we});
        end
        rst = 1'b0;
    endtask

    task automatic test_arith;
        int n;
        do_reset();
        load_arith();
        wq.push_back('{4'd13, 8'd110});
        pulse_start();
        run_to_halt(n);
        checks++;
        if (n !== 13) begin
            errors++;
            $display("FAIL arith_cycles got %0d want 13", n);
        end
        checks++;
        if (acc !== 8'd110 || pc !== 4'd4) begin
            errors++;
            $display("FAIL arith_state got acc=%0d pc=%0d want 110 4", acc, pc);
        end
        checks++;
        if (wq.size() != 0 || mem[13] !== 8'd110) begin
            errors++;
            $display("FAIL arith_store got pending=%0d mem13=%0d want 0 110",
                     wq.size(), mem[13]);
        end
    endtask

    task automatic test_unary;
        logic [7:0] ops  [5] = '{8'h10, 8'h20, 8'h30, 8'h30, 8'h00};
        logic [7:0] vals [5] = '{8'd21, 8'd59, 8'd21, 8'h80, 8'd21};
        logic [7:0] exps [5] = '{8'd234, 8'd29, 8'd42, 8'h01, 8'd0};
        int n;
        for (int i = 0; i < 5; i++) begin
            do_reset();
            mem[0]  = 8'h6E;
            mem[1]  = ops[i];
            mem[2]  = 8'h90;
            mem[14] = vals[i];
            pulse_start();
            run_to_halt(n);
            checks++;
            if (acc !== exps[i] || n !== 9) begin
                errors++;
                $display("FAIL unary[%0d] got acc=%0d cycles=%0d want acc=%0d cycles=9",
                         i, acc, n, exps[i]);
            end
        end
    endtask

    task automatic test_jump_wrap;
        do_reset();
        mem[0]  = 8'h7F;
        mem[15] = 8'h10;
        pulse_start();
        repeat (2) begin @(posedge clk); #1; end
        checks++;
        if (pc !== 4'd15) begin
            errors++;
            $display("FAIL jmp_pc got %0d want 15", pc);
        end
        repeat (2) begin @(posedge clk); #1; end
        checks++;
        if (pc !== 4'd0 || acc !== 8'h00) begin
            errors++;
            $display("FAIL wrap_pc got pc=%0d acc=%0h want 0 00", pc, acc);
        end
        @(posedge clk);
        #1;
        checks++;
        if (acc !== 8'hFF) begin
            errors++;
            $display("FAIL loop1 got acc=%0h want ff", acc);
        end
        repeat (5) begin @(posedge clk); #1; end
        checks++;
        if (acc !== 8'h00) begin
            errors++;
            $display("FAIL loop2 got acc=%0h want 00", acc);
        end
        repeat (5) begin @(posedge clk); #1; end
        checks++;
        if (acc !== 8'hFF || busy !== 1'b1 || halted !== 1'b0) begin
            errors++;
            $display("FAIL loop3 got acc=%0h busy=%0b halted=%0b want ff 1 0",
                     acc, busy, halted);
        end
    endtask

    task automatic test_illegal;
        int n;
        do_reset();
        mem[0]  = 8'h6E;
        mem[1]  = 8'hA0;
        mem[2]  = 8'h90;
        mem[14] = 8'd77;
        pulse_start();
        run_to_halt(n);
        checks++;
`ifdef ACC_CTRL_TRAP_EN
        if (n !== 6 || pc !== 4'd2 || illegal !== 1'b1 || acc !== 8'd77) begin
            errors++;
            $display("FAIL illegal_trap got n=%0d pc=%0d ill=%0b acc=%0d want 6 2 1 77",
                     n, pc, illegal, acc);
        end
`else
        if (n !== 8 || pc !== 4'd3 || illegal !== 1'b0 || acc !== 8'd77) begin
            errors++;
            $display("FAIL illegal_nop got n=%0d pc=%0d ill=%0b acc=%0d want 8 3 0 77",
                     n, pc, illegal, acc);
        end
`endif
    endtask

    task automatic test_reset_mid;
        int n;
        do_reset();
        mem[0]  = 8'h6E;
        mem[1]  = 8'h5D;
        mem[2]  = 8'h90;
        mem[14] = 8'd51;
        pulse_start();
        repeat (6) begin @(posedge clk); #1; end
        rst = 1'b1;
        #1;
        checks++;
        if (mem_we !== 1'b0 || mem_addr !== 4'd13 || acc !== 8'd51) begin
            errors++;
            $display("FAIL rst_edge got we=%0b addr=%0d acc=%0d want 0 13 51",
                     mem_we, mem_addr, acc);
        end
        @(posedge clk);
        #1;
        checks++;
        if (pc !== 4'd0 || acc !== 8'd0 || busy !== 1'b0 || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL rst_after got pc=%0d acc=%0d busy=%0b we=%0b want 0 0 0 0",
                     pc, acc, busy, mem_we);
        end
        checks++;
        if (mem[13] !== 8'd0) begin
            errors++;
            $display("FAIL rst_nowrite got mem13=%0d want 0", mem[13]);
        end
        rst = 1'b0;
        wq.push_back('{4'd13, 8'd51});
        pulse_start();
        run_to_halt(n);
        checks++;
        if (n !== 9 || pc !== 4'd3 || wq.size() != 0 || mem[13] !== 8'd51) begin
            errors++;
            $display("FAIL rerun got n=%0d pc=%0d pending=%0d mem13=%0d want 9 3 0 51",
                     n, pc, wq.size(), mem[13]);
        end
    endtask

    task automatic test_start_ignored;
        int n;
        do_reset();
        load_arith();
        wq.push_back('{4'd13, 8'd110});
        pulse_start();
        repeat (3) begin @(posedge clk); #1; end
        pulse_start();
        run_to_halt(n);
        checks++;
        if (n + 4 !== 13 || acc !== 8'd110) begin
            errors++;
            $display("FAIL start_busy got cycles=%0d acc=%0d want 13 110", n + 4, acc);
        end
        pulse_start();
        @(posedge clk);
        #1;
        checks++;
        if (halted !== 1'b1 || busy !== 1'b0 || pc !== 4'd4 || acc !== 8'd110) begin
            errors++;
            $display("FAIL start_halt got h=%0b b=%0b pc=%0d acc=%0d want 1 0 4 110",
                     halted, busy, pc, acc);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        test_reset();
        test_arith();
        test_unary();
        test_jump_wrap();
        test_illegal();
        test_reset_mid();
        test_start_ignored();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
